// File: rtl/uart_txrx_top.sv
// uart_txrx_top: 8N1 UART transceiver with a fractional 16x baud-tick generator.
// Ports:
//   sclk, rst_n            system clock, asynchronous active-low reset
//   txd_data_i, txd_en_i   byte to send and level transmit request
//   txd_flag_o             one-cycle pulse at the end of each stop bit sent
//   txd                    serial output, idle high
//   rxd                    asynchronous serial input
//   rxd_data_o             last correctly received byte
//   rxd_flag_o, rxd_err_o  one-cycle pulses for a good byte / framing error
module uart_txrx_top #(
    parameter logic [31:0] DEVIDE_CNT = 32'd6597069,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic [7:0] txd_data_i,
    input  logic       txd_en_i,
    output logic       txd_flag_o,
    output logic       txd,
    input  logic       rxd,
    output logic [7:0] rxd_data_o,
    output logic       rxd_flag_o,
    output logic       rxd_err_o
);

    localparam int unsigned ACC_W = 32;
    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] MID_TICK  = CNT_W'(OVERSAMPLE / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

    // Phase accumulator; the carry-out is the oversampling tick
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   acc_sum;
    logic             tick;

    assign acc_sum = {1'b0, acc} + {1'b0, DEVIDE_CNT};

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            tick <= 1'b0;
        end else begin
            acc  <= acc_sum[ACC_W-1:0];
            tick <= acc_sum[ACC_W];
        end
    end

    // TX state
    tx_state_t        tx_state, tx_state_d;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_d;
    logic [2:0]       tx_bit, tx_bit_d;
    logic [7:0]       tx_shift, tx_shift_d;
    logic             txd_d, txd_flag_d;
    logic             tx_bit_end;

    assign tx_bit_end = tick && (tx_cnt == LAST_TICK);

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state   <= TX_IDLE;
            tx_cnt     <= '0;
            tx_bit     <= '0;
            tx_shift   <= '0;
            txd        <= 1'b1;
            txd_flag_o <= 1'b0;
        end else begin
            tx_state   <= tx_state_d;
            tx_cnt     <= tx_cnt_d;
            tx_bit     <= tx_bit_d;
            tx_shift   <= tx_shift_d;
            txd        <= txd_d;
            txd_flag_o <= txd_flag_d;
        end
    end

    // TX next state; txd_d is the value the line takes after this edge
    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt;
        tx_bit_d   = tx_bit;
        tx_shift_d = tx_shift;
        txd_d      = txd;
        txd_flag_d = 1'b0;
        if (tick && tx_state != TX_IDLE) begin
            tx_cnt_d = tx_cnt + CNT_W'(1);
        end
        case (tx_state)
            TX_IDLE: begin
                txd_d = 1'b1;
                // Skip the flag cycle so dropping the request right after the flag ends the burst
                if (txd_en_i && !txd_flag_o) begin
                    tx_shift_d = txd_data_i;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    txd_d      = 1'b0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    txd_d      = tx_shift[0];
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    if (tx_bit == 3'd7) begin
                        txd_d      = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_shift_d = tx_shift >> 1;
                        txd_d      = tx_shift[1];
                        tx_bit_d   = tx_bit + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    txd_flag_d = 1'b1;
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // RX synchroniser plus one history flop for start-edge detection
    logic [1:0] rx_sync;
    logic       rx_prev;
    logic       rx_s;

    assign rx_s = rx_sync[1];

    rx_state_t        rx_state, rx_state_d;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_d;
    logic [2:0]       rx_bit, rx_bit_d;
    logic [7:0]       rx_shift, rx_shift_d;
    logic [7:0]       rxd_data_d;
    logic             rxd_flag_d, rxd_err_d;
    logic             rx_bit_end;

    assign rx_bit_end = tick && (rx_cnt == LAST_TICK);

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync    <= 2'b11;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rxd_data_o <= '0;
            rxd_flag_o <= 1'b0;
            rxd_err_o  <= 1'b0;
        end else begin
            rx_sync    <= {rx_sync[0], rxd};
            rx_prev    <= rx_s;
            rx_state   <= rx_state_d;
            rx_cnt     <= rx_cnt_d;
            rx_bit     <= rx_bit_d;
            rx_shift   <= rx_shift_d;
            rxd_data_o <= rxd_data_d;
            rxd_flag_o <= rxd_flag_d;
            rxd_err_o  <= rxd_err_d;
        end
    end

    // RX next state: validate start at its centre, then sample every 16 ticks
    always_comb begin
        rx_state_d = rx_state;
        rx_cnt_d   = rx_cnt;
        rx_bit_d   = rx_bit;
        rx_shift_d = rx_shift;
        rxd_data_d = rxd_data_o;
        rxd_flag_d = 1'b0;
        rxd_err_d  = 1'b0;
        if (tick && rx_state != RX_IDLE && rx_state != RX_BREAK) begin
            rx_cnt_d = rx_cnt + CNT_W'(1);
        end
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_s) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (tick && rx_cnt == MID_TICK) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_bit_end) begin
                    rx_shift_d = {rx_s, rx_shift[7:1]};
                    rx_bit_d   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (rx_bit_end) begin
                    if (rx_s) begin
                        rxd_data_d = rx_shift;
                        rxd_flag_d = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rxd_err_d  = 1'b1;
                        rx_state_d = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                // Re-arm only once the line is back at idle
                if (rx_s) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_txrx_top.sv
// tb_uart_txrx_top: randomized self-checking bench for uart_txrx_top.
// The baud increment is raised so one tick is about 6.5 sclk, keeping frames near 1040 cycles.
module tb_uart_txrx_top;

    localparam logic [31:0] DIV     = 32'd660764199;
    localparam int          BIT_CYC = 104;

    logic       sclk = 1'b0;
    logic       rst_n;
    logic [7:0] txd_data_i;
    logic       txd_en_i;
    logic       txd_flag_o;
    logic       txd;
    logic       rxd;
    logic [7:0] rxd_data_o;
    logic       rxd_flag_o;
    logic       rxd_err_o;

    logic loop_en;
    logic rx_drv;

    assign rxd = loop_en ? txd : rx_drv;

    uart_txrx_top #(.DEVIDE_CNT(DIV)) dut (
        .sclk       (sclk),
        .rst_n      (rst_n),
        .txd_data_i (txd_data_i),
        .txd_en_i   (txd_en_i),
        .txd_flag_o (txd_flag_o),
        .txd        (txd),
        .rxd        (rxd),
        .rxd_data_o (rxd_data_o),
        .rxd_flag_o (rxd_flag_o),
        .rxd_err_o  (rxd_err_o)
    );

    always #5 sclk = ~sclk;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned tick_cnt = 0;
    int unsigned tx_flags = 0;
    int unsigned rx_flags = 0;
    int unsigned rx_errs = 0;
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];

    // Event monitor sampled on the falling edge
    always @(negedge sclk) begin
        if (dut.tick === 1'b1) tick_cnt <= tick_cnt + 1;
        if (txd_flag_o === 1'b1) tx_flags <= tx_flags + 1;
        if (rxd_err_o === 1'b1) rx_errs <= rx_errs + 1;
        if (rxd_flag_o === 1'b1) begin
            rx_flags <= rx_flags + 1;
            rx_q.push_back(rxd_data_o);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge sclk);
    endtask

    // Send one byte; check each bit at its centre, one flag, then drop the request
    task automatic send_byte(input logic [7:0] b);
        logic [9:0]  fr;
        int unsigned t0;
        int unsigned f0;
        int          n;
        fr = {1'b1, b, 1'b0};
        f0 = tx_flags;
        @(negedge sclk);
        txd_data_i = b;
        txd_en_i   = 1'b1;
        n = 0;
        while (txd !== 1'b0 && n < 200) begin
            @(negedge sclk);
            n++;
        end
        check("tx_start_seen", 32'(txd), 32'd0);
        t0 = tick_cnt;
        txd_data_i = ~b;
        for (int unsigned k = 0; k < 10; k++) begin
            n = 0;
            while ((tick_cnt - t0) < (16 * k + 8) && n < 400) begin
                @(negedge sclk);
                n++;
            end
            check($sformatf("tx_bit%0d", k), 32'(txd), 32'(fr[k]));
        end
        n = 0;
        while (txd_flag_o !== 1'b1 && n < 1000) begin
            @(negedge sclk);
            n++;
        end
        txd_en_i = 1'b0;
        check("tx_frame_ticks_ok", 32'((tick_cnt - t0) >= 159 && (tick_cnt - t0) <= 161), 32'd1);
        wait_cycles(150);
        check("tx_one_flag", tx_flags - f0, 32'd1);
        check("tx_idle_after", 32'(txd), 32'd1);
        if (loop_en) exp_q.push_back(b);
    endtask

    // Drive a raw frame on rxd with a chosen bit period and stop value
    task automatic drive_frame(input logic [7:0] b, input logic stop, input int bit_cyc,
                               input int idle_cyc);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx_drv = fr[k];
            wait_cycles(bit_cyc);
        end
        rx_drv = 1'b1;
        wait_cycles(idle_cyc);
        if (stop) exp_q.push_back(b);
    endtask

    initial begin
        #800us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          last_tick;
        int          tick_seen;
        logic        prev_tick;
        int unsigned f0;
        int unsigned e0;
        int          n;
        logic [7:0]  last_good;

        rst_n      = 1'b0;
        txd_en_i   = 1'b0;
        txd_data_i = 8'h00;
        loop_en    = 1'b0;
        rx_drv     = 1'b1;
        #100;
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_txd_flag", 32'(txd_flag_o), 32'd0);
        check("rst_rxd_flag", 32'(rxd_flag_o), 32'd0);
        check("rst_rxd_err", 32'(rxd_err_o), 32'd0);
        check("rst_rxd_data", 32'(rxd_data_o), 32'd0);
        @(negedge sclk);
        rst_n = 1'b1;

        // Tick rate: 1000 cycles at 6.5 cycles per tick gives 153 or 154 ticks
        wait_cycles(20);
        last_tick = -1;
        tick_seen = 0;
        prev_tick = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge sclk);
            if (dut.tick === 1'b1) begin
                tick_seen++;
                check("tick_width", 32'(prev_tick), 32'd0);
                if (last_tick >= 0)
                    check($sformatf("tick_gap_%0d_ok", c - last_tick),
                          32'((c - last_tick) == 6 || (c - last_tick) == 7), 32'd1);
                last_tick = c;
            end
            prev_tick = dut.tick;
        end
        check("tick_count_ok", 32'(tick_seen == 153 || tick_seen == 154), 32'd1);

        // TX only
        send_byte(8'hCB);

        // Loopback, fixed then random bytes
        loop_en = 1'b1;
        wait_cycles(20);
        send_byte(8'hCB);
        wait_cycles(500);
        send_byte(8'h7B);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        check("loop_no_err", rx_errs, 32'd0);
        check("loop_flag_count", rx_flags, 32'(exp_q.size()));

        // Direct RX stimulus
        loop_en = 1'b0;
        rx_drv  = 1'b1;
        wait_cycles(50);
        f0 = rx_flags;
        e0 = rx_errs;
        rx_drv = 1'b0;
        wait_cycles(13);
        rx_drv = 1'b1;
        wait_cycles(300);
        check("glitch_no_flag", rx_flags - f0, 32'd0);
        check("glitch_no_err", rx_errs - e0, 32'd0);

        drive_frame(8'($urandom), 1'b1, BIT_CYC, 150);
        drive_frame(8'($urandom), 1'b1, 101, 150);
        drive_frame(8'($urandom), 1'b1, 107, 150);
        drive_frame(8'($urandom), 1'b1, BIT_CYC, 0);
        drive_frame(8'($urandom), 1'b1, BIT_CYC, 150);
        check("rx_last_good", 32'(rxd_data_o), 32'(exp_q[$]));

        last_good = exp_q[$];
        f0 = rx_flags;
        e0 = rx_errs;
        drive_frame(8'($urandom), 1'b0, BIT_CYC, 150);
        check("ferr_pulse", rx_errs - e0, 32'd1);
        check("ferr_no_flag", rx_flags - f0, 32'd0);
        check("ferr_data_kept", 32'(rxd_data_o), 32'(last_good));
        drive_frame(8'($urandom), 1'b1, BIT_CYC, 150);

        // Continuous TX with request held high, then reset mid-frame
        loop_en = 1'b1;
        wait_cycles(20);
        f0 = tx_flags;
        txd_data_i = 8'h55;
        txd_en_i   = 1'b1;
        for (int f = 0; f < 3; f++) begin
            n = 0;
            while (txd_flag_o !== 1'b1 && n < 2000) begin
                @(negedge sclk);
                n++;
            end
            check("cont_flag_seen", 32'(txd_flag_o), 32'd1);
            exp_q.push_back(8'h55);
            n = 0;
            @(negedge sclk);
            n++;
            while (txd !== 1'b0 && n < 10) begin
                @(negedge sclk);
                n++;
            end
            check("cont_no_gap", 32'(n <= 3), 32'd1);
        end
        wait_cycles(350);
        check("cont_flag_count", tx_flags - f0, 32'd3);
        check("cont_mid_frame_low", 32'(txd === 1'b0 || dut.tx_state != 2'd0), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_txd", 32'(txd), 32'd1);
        check("midrst_txd_flag", 32'(txd_flag_o), 32'd0);
        check("midrst_rxd_data", 32'(rxd_data_o), 32'd0);
        txd_en_i = 1'b0;
        #100;
        @(negedge sclk);
        rst_n = 1'b1;
        wait_cycles(50);
        check("post_rst_idle", 32'(txd), 32'd1);
        send_byte(8'($urandom));

        // Scoreboard of every byte reported by the receiver
        wait_cycles(20);
        check("rx_count", 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("rx_byte%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
        check("rx_err_total", rx_errs, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_txrx_top.md
Name: uart_txrx_top

Overview:
- 8N1 UART transceiver with an integrated fractional baud-tick generator.
- A 32-bit phase accumulator produces a 16x-oversampling enable pulse.
- The TX path serialises a byte on request.
- The RX path oversamples, deserialises and reports received bytes. Loopback (txd wired to rxd) is the primary system-level use.

Parameters:
- DEVIDE_CNT, 32'd6597069: phase increment per sclk. Tick rate = f_sclk * DEVIDE_CNT / 2^32; the default gives 153.6 kHz (9600 baud x 16) at 100 MHz.
- OVERSAMPLE, 16: ticks per bit; fixed, not intended to be overridden.

Ports:
- sclk  in  1  system clock (100 MHz nominal).
- rst_n  in  1  reset; asynchronous, active-low.
- txd_data_i  in  8  byte to transmit; sampled when a frame is accepted.
- txd_en_i  in  1  level transmit request.
- txd_flag_o  out  1  one-sclk pulse at the end of the stop bit of each transmitted frame.
- txd  out  1  serial output; idle high.
- rxd  in  1  serial input; asynchronous.
- rxd_data_o  out  8  last correctly received byte.
- rxd_flag_o  out  1  one-sclk pulse when rxd_data_o is updated.
- rxd_err_o  out  1  one-sclk pulse on stop-bit (framing) error.

Behaviour:
- Reset: accumulator = 0, txd = 1, all flags = 0, rxd_data_o = 0, both FSMs in IDLE.

Baud generator:
- Every sclk: acc <= acc + DEVIDE_CNT, modulo 2^32.
- tick = registered carry-out of that add; exactly one sclk wide.
- Long-run average period = 2^32 / DEVIDE_CNT sclk, about 651.04 for the default.
- Individual periods are 651 or 652 sclk; no cumulative drift.
- Free-running; not restarted by frames.

TX FSM (IDLE, START, DATA, STOP):
- IDLE: txd = 1. If txd_en_i = 1, latch txd_data_i into the shift register, clear the tick counter and go to START.
- START: txd = 0 for 16 ticks.
- DATA: bits 0..7, LSB first, 16 ticks each.
- STOP: txd = 1 for 16 ticks.
- On the 16th tick of STOP: pulse txd_flag_o for one sclk and return to IDLE.
- txd_en_i is level-sensitive. If it is still high in IDLE, the next frame starts immediately with freshly sampled data. Deasserting it in the cycle after txd_flag_o yields exactly one frame.
- Changes to txd_en_i or txd_data_i during a frame are ignored.
- txd is driven from a register; no glitches.
- First tick boundary after acceptance: start-bit length may be 15–16 ticks depending on tick phase. All later bits are exactly 16 ticks.

RX:
- rxd passes through a 2-flop synchroniser. All logic uses the synchronised value.
- IDLE: on a 1->0 edge, go to START and clear the tick counter.
- START: on the 8th tick re-sample.
  - If high, treat as a glitch and return to IDLE with no flags.
  - Else go to DATA and restart the count.
- DATA: sample at each 16th tick (bit centre), shift in LSB first, 8 bits.
- STOP: at the 16th tick sample.
  - If 1: load rxd_data_o and pulse rxd_flag_o.
  - If 0: pulse rxd_err_o, leave rxd_data_o unchanged, and wait for the line to return high before re-arming.
- Return to IDLE after the stop sample; a back-to-back start bit must be caught.
- Tolerates ±3% baud mismatch.
- Asynchronous reset mid-frame aborts both FSMs immediately. Outputs take reset values; txd goes high within the same cycle via the async reset.

Test Plan:
- Reset: hold rst_n = 0 for 100 ns -> txd = 1; txd_flag_o, rxd_flag_o, rxd_err_o = 0; rxd_data_o = 0x00.
- Tick rate: default DEVIDE_CNT, 100 MHz, 1 ms free run -> 153 or 154 ticks; each tick 1 sclk wide; spacing 651/652 sclk.
- TX 0xCB: txd_en_i = 1 at 200 ns, drop after txd_flag_o -> txd bit sequence 0,1,1,0,1,0,0,1,1,1 (16 ticks each); frame about 1.04 ms; exactly one txd_flag_o pulse.
- Loopback: txd tied to rxd; send 0xCB, wait 1.5 ms, send 0x7B -> rxd_flag_o pulses twice; rxd_data_o = 0xCB, then 0x7B; no rxd_err_o.
- RX robustness:
  - rxd low glitch of 2 ticks -> no flags.
  - Frame with stop bit forced 0 -> rxd_err_o pulse; rxd_data_o unchanged.
- Continuous TX: txd_en_i held high with 0x55 -> back-to-back frames with no idle gap; one txd_flag_o per frame. Reset mid-frame -> txd = 1 immediately; clean restart afterwards.
